// File: rtl/aes_key_sched_ctrl_128_pkg.sv
// Shared constants and byte-level helpers for the AES-128 key schedule controller.
// The S-box is a flat ROM indexed directly by the input byte.
package aes_pkg;

    localparam int unsigned AES_NR_128 = 10;
    localparam logic [7:0]  RCON_INIT  = 8'h01;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StDone
    } ks_state_e;

    // Row r holds S-box outputs for inputs r*16 .. r*16+15, element 0 leftmost.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_128_expand.sv
// One combinational AES-128 key-expansion step: round key r-1 plus rcon -> round key r.
// Words are big-endian, w0 in the most significant 32 bits.
module aes_key_expand_128
    import aes_pkg::*;
(
    input  logic [127:0] i_rk_prev,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_rk_next
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_rk_prev[127:96];
    assign w_w1 = i_rk_prev[95:64];
    assign w_w2 = i_rk_prev[63:32];
    assign w_w3 = i_rk_prev[31:0];

    assign w_temp = sub_word(rot_word(w_w3)) ^ {i_rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_rk_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_key_sched_ctrl_128.sv
// Iterative AES-128 key schedule: one round key per cycle through a single shared
// expander, results held in an 11-entry round-key store with a combinational read port.
module aes_key_sched_ctrl_128
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    localparam logic [3:0] LastRound = 4'(AES_NR_128);

    ks_state_e    r_state;
    logic [3:0]   r_cnt;
    logic [7:0]   r_rcon;
    logic         r_done;
    logic         r_keys_valid;
    logic [127:0] r_rk [AES_NR_128 + 1];

    logic         w_key_ready;
    logic         w_accept;
    logic [3:0]   w_prev_idx;
    logic [127:0] w_rk_prev;
    logic [127:0] w_rk_next;

    assign w_key_ready = (r_state != StExpand);
    assign w_accept    = key_valid && w_key_ready;
    assign w_prev_idx  = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
    assign w_rk_prev   = r_rk[w_prev_idx];

    aes_key_expand_128 u_expand (
        .i_rk_prev (w_rk_prev),
        .i_rcon    (r_rcon),
        .o_rk_next (w_rk_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_rcon       <= RCON_INIT;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (key_valid) begin
                        r_state      <= StExpand;
                        r_cnt        <= 4'd1;
                        r_rcon       <= RCON_INIT;
                        r_keys_valid <= 1'b0;
                    end
                end
                StExpand: begin
                    r_rcon <= xtime(r_rcon);
                    // Counter parks at the last round so it never leaves 0..10.
                    if (r_cnt == LastRound) begin
                        r_state      <= StDone;
                        r_done       <= 1'b1;
                        r_keys_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Store is left unreset; reset only blocks writes so an aborted load cannot start.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_accept) begin
                r_rk[0] <= key_in;
            end else if (r_state == StExpand) begin
                r_rk[r_cnt] <= w_rk_next;
            end
        end
    end

    always_comb begin
        rk_out = '0;
        if (rk_idx <= LastRound) begin
            rk_out = r_rk[rk_idx];
        end
    end

    assign key_ready  = w_key_ready;
    assign busy       = (r_state == StExpand);
    assign done       = r_done;
    assign keys_valid = r_keys_valid;

endmodule

// File: tb/tb_aes_key_sched_ctrl_128.sv
// Scoreboard bench for aes_key_sched_ctrl_128: FIPS-197 style word-array key schedule
// model, expected schedules queued at accept and compared when done pulses.
module tb_aes_key_sched_ctrl_128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   rk_idx = '0;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [127:0] rk_out;

    aes_key_sched_ctrl_128 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [10:0][127:0] rk;
        logic [31:0]        due;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         a_cyc = -100;
    logic [7:0] sb [256];
    logic [7:0] rcon_ref [10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none", nm);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from first principles: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                    ^ 8'h63;
        end
    endtask

    function automatic logic [10:0][127:0] model_sched(input logic [127:0] k);
        logic [31:0]        w [44];
        logic [31:0]        t;
        logic [7:0]         rc;
        logic [10:0][127:0] r;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int j = 0; j < 11; j++) r[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [127:0] k, input bit pin1, input logic [127:0] rk1,
                        input bit pin10, input logic [127:0] rk10);
        int   n = 0;
        exp_t e;
        key_in    = k;
        key_valid = 1'b1;
        while (!key_ready && n < 40) begin
            step(1);
            n++;
        end
        if (!key_ready) begin
            key_valid = 1'b0;
            flag("accept_timeout");
            return;
        end
        e.rk = model_sched(k);
        if (pin1) e.rk[1] = rk1;
        if (pin10) e.rk[10] = rk10;
        step(1);
        key_valid = 1'b0;
        a_cyc     = cyc;
        e.due     = 32'(cyc + 10);
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30) begin
            step(1);
            n++;
        end
        if (!done) flag("done_timeout");
    endtask

    // Monitor: rcon sequence while busy, full schedule readback on each done pulse.
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (busy === 1'b1) begin
            k = cyc - a_cyc;
            if (k >= 0 && k < 10) chk($sformatf("rcon[%0d]", k), 128'(dut.r_rcon), 128'(rcon_ref[k]));
            else flag("busy_window");
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_done");
            end else begin
                e = exp_q.pop_front();
                chk("done_latency", 128'(cyc), 128'(e.due));
                chk("keys_valid_at_done", 128'(keys_valid), 128'(1));
                chk("busy_at_done", 128'(busy), 128'(0));
                for (int i = 0; i < 11; i++) begin
                    rk_idx = 4'(i);
                    #1;
                    chk($sformatf("rk[%0d]", i), rk_out, e.rk[i]);
                end
                rk_idx = 4'd12;
                #1;
                chk("rk_idx12_zero", rk_out, 128'h0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        exp_t         e;
        rcon_ref = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        build_sbox();

        rst_n = 1'b0;
        step(2);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_key_ready", 128'(key_ready), 128'(1));
        chk("rst_keys_valid", 128'(keys_valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        step(1);

        send(128'h2b7e151628aed2a6abf7158809cf4f3c,
             1'b1, 128'ha0fafe1788542cb123a339392a6c7605,
             1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_done();
        step(1);
        send(128'h0, 1'b0, 128'h0, 1'b1, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        wait_done();

        // key_valid held with a different key throughout EXPAND must be ignored
        step(2);
        k         = {$urandom, $urandom, $urandom, $urandom};
        key_in    = k;
        key_valid = 1'b1;
        e.rk      = model_sched(k);
        step(1);
        a_cyc = cyc;
        e.due = 32'(cyc + 10);
        exp_q.push_back(e);
        key_in = ~k;
        for (int i = 0; i < 8; i++) begin
            chk("ready_low_in_expand", 128'(key_ready), 128'(0));
            chk("busy_in_expand", 128'(busy), 128'(1));
            step(1);
        end
        key_valid = 1'b0;
        wait_done();
        step(2);
        chk("single_done", 128'(done), 128'(0));

        // reset in the middle of an expansion
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0, 1'b0, 128'h0);
        step(4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        exp_q.delete();
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_keys_valid", 128'(keys_valid), 128'(0));
        chk("abort_key_ready", 128'(key_ready), 128'(1));
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_done", 128'(done), 128'(0));
            step(1);
        end
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0, 1'b0, 128'h0);
        wait_done();

        // back-to-back: next key offered in the done cycle
        step(1);
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0, 1'b0, 128'h0);
        wait_done();
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0, 1'b0, 128'h0);
        chk("b2b_keys_valid_drop", 128'(keys_valid), 128'(0));
        chk("b2b_busy", 128'(busy), 128'(1));
        wait_done();

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) step($urandom_range(1, 3));
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0, 1'b0, 128'h0);
            wait_done();
        end

        step(3);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
